// File: rtl/mask_pkg.sv
// Shared mode encodings and the mask transform used by mask_stage.
// Widths up to MAX_W are handled by zero-extending into the helper.
package mask_pkg;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] apply_mask(
        input logic [MAX_W-1:0] d,
        input logic [MAX_W-1:0] m,
        input logic [1:0]       mode
    );
        logic [MAX_W-1:0] r;
        r = d;
        unique case (mode)
            MODE_AND:  r = d & m;
            MODE_OR:   r = d | m;
            MODE_XOR:  r = d ^ m;
            MODE_PASS: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mask_fifo2.sv
// Two-entry FIFO with registered occupancy; slot0 is always the head.
// Push at full and pop at empty are ignored.
module mask_fifo2
    import mask_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = slot0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= wdata;
                    else               slot1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                // Only reachable at occupancy 1: new word replaces the head.
                2'b11: slot0 <= wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mask_stage.sv
// Buffered mask stage: transforms accepted words with the current mask/mode,
// queues them in a 2-entry FIFO and counts delivered words.
module mask_stage
    import mask_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_MASK = WIDTH'(4'b0111),
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_wdata,
    input  logic [1:0]       mode_wdata,
    output logic [WIDTH-1:0] mask_q,
    output logic [1:0]       mode_q,
    output logic [CNT_W-1:0] xfer_count
);

    logic [1:0]       occ;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] xf;

    // Full buffer blocks intake even when a pop happens in the same cycle.
    assign in_ready  = !reset && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign xf = WIDTH'(apply_mask(MAX_W'(in_data), MAX_W'(mask_q), mode_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= DEFAULT_MASK;
            mode_q <= MODE_AND;
        end else if (mask_we) begin
            mask_q <= mask_wdata;
            mode_q <= mode_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

    mask_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (xf),
        .count (occ),
        .head  (out_data)
    );

endmodule

// File: tb/tb_mask_stage.sv
// Directed bench for mask_stage: queue-based model checked every cycle,
// plus literal expectations per scenario; a CNT_W=3 copy covers wrap.
module tb_mask_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        out_ready;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [1:0]  mode_wdata;

    logic        in_ready, out_valid;
    logic [3:0]  out_data, mask_q;
    logic [1:0]  mode_q;
    logic [15:0] xfer_count;

    logic        w_in_ready, w_out_valid;
    logic [3:0]  w_out_data, w_mask_q;
    logic [1:0]  w_mode_q;
    logic [2:0]  w_xfer_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mask_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .mode_wdata(mode_wdata),
        .mask_q(mask_q), .mode_q(mode_q), .xfer_count(xfer_count)
    );

    mask_stage #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .mode_wdata(mode_wdata),
        .mask_q(w_mask_q), .mode_q(w_mode_q), .xfer_count(w_xfer_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] model_xf(input logic [3:0] d,
                                            input logic [3:0] m,
                                            input logic [1:0] mode);
        case (mode)
            2'd0:    return d & m;
            2'd1:    return d | m;
            2'd2:    return d ^ m;
            default: return d;
        endcase
    endfunction

    // Model state: pending words, config, delivered count.
    logic [3:0] mq[$];
    logic [3:0] m_mask = 4'b0111;
    logic [1:0] m_mode = 2'b00;
    int         m_cnt  = 0;

    always @(posedge clk) begin : model
        bit acc, dlv;
        if (reset) begin
            mq.delete();
            m_mask = 4'b0111;
            m_mode = 2'b00;
            m_cnt  = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            dlv = (mq.size() > 0) && out_ready;
            if (dlv) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (acc) mq.push_back(model_xf(in_data, m_mask, m_mode));
            if (mask_we) begin
                m_mask = mask_wdata;
                m_mode = mode_wdata;
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("in_ready", 32'(in_ready), 32'(!reset && mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("mask_q", 32'(mask_q), 32'(m_mask));
        chk("mode_q", 32'(mode_q), 32'(m_mode));
        chk("xfer_count", 32'(xfer_count), 32'(m_cnt % 65536));
        chk("w_xfer_count", 32'(w_xfer_count), 32'(m_cnt % 8));
        chk("w_out_valid", 32'(w_out_valid), 32'(mq.size() > 0));
    end

    logic [3:0] log_q[$];
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) log_q.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b1; in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
        mask_we = 1'b0; mask_wdata = 4'd0; mode_wdata = 2'd0;

        // Reset held three cycles with a word offered.
        repeat (3) begin
            step();
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready_low", 32'(in_ready), 32'd1);
        chk("rst_mask", 32'(mask_q), 32'h7);
        chk("rst_mode", 32'(mode_q), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);

        // Streaming 0..15 with default AND 0111.
        log_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
            if (i == 0) begin
                chk("lat_valid", 32'(out_valid), 32'd1);
                chk("lat_data", 32'(out_data), 32'd0);
            end
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream_len", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            chk("stream_word", 32'(log_q[i]), 32'(i % 8));
        chk("stream_xfer", 32'(xfer_count), 32'd16);

        // Backpressure: 5 and 6 fill the buffer, 7 waits.
        log_q.delete();
        out_ready = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'hF; mode_wdata = 2'd0;
        step();
        mask_we = 1'b0;
        in_valid = 1'b1; in_data = 4'd5; step();
        in_data = 4'd6; step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_data = 4'd7; step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_head_held", 32'(out_data), 32'd5);
        out_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("bp_accept_7", 32'(ok), 32'd1);
        repeat (3) step();
        chk("bp_len", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("bp_w0", 32'(log_q[0]), 32'd5);
            chk("bp_w1", 32'(log_q[1]), 32'd6);
            chk("bp_w2", 32'(log_q[2]), 32'd7);
        end
        chk("bp_xfer", 32'(xfer_count), 32'd19);

        // Mask write in the same cycle as an accept.
        log_q.delete();
        in_valid = 1'b1; in_data = 4'b0011;
        mask_we = 1'b1; mask_wdata = 4'b1010; mode_wdata = 2'b10;
        step();
        mask_we = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("mw_len", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("mw_old", 32'(log_q[0]), 32'b0011);
            chk("mw_new", 32'(log_q[1]), 32'b1001);
        end
        chk("mw_mask", 32'(mask_q), 32'b1010);
        chk("mw_mode", 32'(mode_q), 32'b10);

        // Reset with two stalled words and a prior OR 1100 write.
        out_ready = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'b1100; mode_wdata = 2'b01;
        step();
        mask_we = 1'b0;
        in_valid = 1'b1; in_data = 4'd1; step();
        in_data = 4'd2; step();
        chk("mr_head", 32'(out_data), 32'b1101);
        reset = 1'b1; out_ready = 1'b1; in_data = 4'd9;
        mask_we = 1'b1; mask_wdata = 4'b0001; mode_wdata = 2'b11;
        step();
        reset = 1'b0; in_valid = 1'b0; mask_we = 1'b0;
        #1;
        log_q.delete();
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_mask", 32'(mask_q), 32'h7);
        chk("mr_mode", 32'(mode_q), 32'd0);
        chk("mr_xfer", 32'(xfer_count), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step();
        chk("mr_no_old", 32'(log_q.size()), 32'd0);

        // Nine deliveries: 3-bit counter wraps to 1.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("wrap_len", 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++)
            chk("wrap_word", 32'(log_q[i]), 32'(i % 8));
        chk("wrap_w_xfer", 32'(w_xfer_count), 32'd1);
        chk("wrap_xfer", 32'(xfer_count), 32'd9);

        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
